// File: rtl/uc_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode map, ALUOp codes,
// FSM state encodings, per-opcode class helpers and the bundled control records.
package uc_pkg;

  // Opcode map (6-bit field); values 29..63 are illegal
  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_XOR   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd5;
  localparam logic [5:0] OP_SUBI  = 6'd6;
  localparam logic [5:0] OP_ANDI  = 6'd7;
  localparam logic [5:0] OP_ORI   = 6'd8;
  localparam logic [5:0] OP_XORI  = 6'd9;
  localparam logic [5:0] OP_NOT   = 6'd10;
  localparam logic [5:0] OP_SL    = 6'd11;
  localparam logic [5:0] OP_SR    = 6'd12;
  localparam logic [5:0] OP_SLT   = 6'd13;
  localparam logic [5:0] OP_MOVE  = 6'd14;
  localparam logic [5:0] OP_LOADI = 6'd15;
  localparam logic [5:0] OP_LOAD  = 6'd16;
  localparam logic [5:0] OP_STORE = 6'd17;
  localparam logic [5:0] OP_BEQ   = 6'd18;
  localparam logic [5:0] OP_BNE   = 6'd19;
  localparam logic [5:0] OP_J     = 6'd20;
  localparam logic [5:0] OP_JR    = 6'd21;
  localparam logic [5:0] OP_JAL   = 6'd22;
  localparam logic [5:0] OP_NOP   = 6'd23;
  localparam logic [5:0] OP_HLT   = 6'd24;
  localparam logic [5:0] OP_NAND  = 6'd25;
  localparam logic [5:0] OP_XNOR  = 6'd26;
  localparam logic [5:0] OP_IN    = 6'd27;
  localparam logic [5:0] OP_OUT   = 6'd28;
  localparam int         OP_COUNT = 29;

  // ALUOp codes; ALU_NOP marks instructions that do not use the ALU
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOT  = 4'b0101;
  localparam logic [3:0] ALU_SL   = 4'b0110;
  localparam logic [3:0] ALU_SR   = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_NAND = 4'b1001;
  localparam logic [3:0] ALU_XNOR = 4'b1010;
  localparam logic [3:0] ALU_PASS = 4'b1011;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    MEM     = 3'd4,
    IO_WAIT = 3'd5,
    WB      = 3'd6,
    HALT    = 3'd7
  } state_t;

  // Static decode of one opcode, before per-state gating
  typedef struct packed {
    logic       reg_dest;
    logic       alu_src;
    logic       slt;
    logic       mem_to_reg;
    logic       io_to_reg;
    logic       jal;
    logic       branch;
    logic       jump;
    logic       jump_r;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       is_mem;
    logic       is_in;
    logic       is_out;
    logic       is_hlt;
    logic       illegal;
    logic [1:0] op_io;
    logic [3:0] alu_op;
  } dec_t;

  // Registered single-bit outputs plus OpIO
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       reg_dest;
    logic       io_to_reg;
    logic       alu_src;
    logic       slt;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       jump_r;
    logic       jal;
    logic       hlt;
    logic       in_req;
    logic [1:0] op_io;
  } ctrl_t;

  // Opcodes whose WB stage writes the register file
  function automatic logic writes_reg(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_XNOR,
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI,
      OP_LOAD, OP_LOADI, OP_MOVE, OP_NOT, OP_SR, OP_SL, OP_SLT, OP_JAL:
        writes_reg = 1'b1;
      default:
        writes_reg = 1'b0;
    endcase
  endfunction

  // Opcodes that go from EXEC into the MEM stage
  function automatic logic uses_mem(input logic [5:0] op);
    case (op)
      OP_LOAD, OP_STORE: uses_mem = 1'b1;
      default:           uses_mem = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder: maps an opcode to its static control fields and
// class bits. Illegal opcodes decode to an all-zero record with ALUOp = no-op.
module uc_decode
  import uc_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output dec_t            dec
);

  logic [5:0] op6_s;

  // Decode the opcode; any value at or above OP_COUNT (including upper bits) is illegal
  always_comb begin
    dec         = {$bits(dec_t){1'b0}};
    dec.alu_op  = ALU_NOP;
    op6_s       = op[5:0];
    dec.illegal = (op >= OP_W'(OP_COUNT));
    if (!dec.illegal) begin
      dec.reg_write = writes_reg(op6_s);
      dec.is_mem    = uses_mem(op6_s);
      case (op6_s)
        OP_ADD:   begin dec.reg_dest = 1'b1; dec.alu_op = ALU_ADD;  end
        OP_SUB:   begin dec.reg_dest = 1'b1; dec.alu_op = ALU_SUB;  end
        OP_AND:   begin dec.reg_dest = 1'b1; dec.alu_op = ALU_AND;  end
        OP_OR:    begin dec.reg_dest = 1'b1; dec.alu_op = ALU_OR;   end
        OP_XOR:   begin dec.reg_dest = 1'b1; dec.alu_op = ALU_XOR;  end
        OP_NAND:  begin dec.reg_dest = 1'b1; dec.alu_op = ALU_NAND; end
        OP_XNOR:  begin dec.reg_dest = 1'b1; dec.alu_op = ALU_XNOR; end
        OP_NOT:   begin dec.reg_dest = 1'b1; dec.alu_op = ALU_NOT;  end
        OP_SL:    begin dec.reg_dest = 1'b1; dec.alu_op = ALU_SL;   end
        OP_SR:    begin dec.reg_dest = 1'b1; dec.alu_op = ALU_SR;   end
        OP_MOVE:  begin dec.reg_dest = 1'b1; dec.alu_op = ALU_PASS; end
        OP_SLT:   begin dec.reg_dest = 1'b1; dec.slt = 1'b1; dec.alu_op = ALU_SLT; end
        OP_ADDI:  begin dec.alu_src = 1'b1; dec.alu_op = ALU_ADD;  end
        OP_SUBI:  begin dec.alu_src = 1'b1; dec.alu_op = ALU_SUB;  end
        OP_ANDI:  begin dec.alu_src = 1'b1; dec.alu_op = ALU_AND;  end
        OP_ORI:   begin dec.alu_src = 1'b1; dec.alu_op = ALU_OR;   end
        OP_XORI:  begin dec.alu_src = 1'b1; dec.alu_op = ALU_XOR;  end
        OP_LOADI: begin dec.alu_src = 1'b1; dec.alu_op = ALU_PASS; end
        OP_LOAD: begin
          dec.alu_src    = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.mem_read   = 1'b1;
          dec.alu_op     = ALU_ADD;
        end
        OP_STORE: begin
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          dec.alu_op    = ALU_ADD;
        end
        OP_BEQ, OP_BNE: begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; end
        OP_J:    dec.jump   = 1'b1;
        OP_JR:   dec.jump_r = 1'b1;
        OP_JAL:  begin dec.jump = 1'b1; dec.jal = 1'b1; end
        OP_HLT:  dec.is_hlt = 1'b1;
        OP_IN: begin
          dec.is_in     = 1'b1;
          dec.io_to_reg = 1'b1;
          dec.mem_write = 1'b1;
          dec.op_io     = 2'b01;
        end
        OP_OUT: begin
          dec.is_out = 1'b1;
          dec.op_io  = 2'b10;
        end
        default: dec.alu_op = ALU_NOP;
      endcase
    end else begin
      dec.alu_op = ALU_NOP;
    end
  end

endmodule

// File: rtl/uc_multicycle.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// variable-latency MEM stage, an IN handshake (IO_WAIT) and a resumable HALT.
// All outputs are registered and reflect the state currently held.
// Optional build macro UC_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT and
// set the sticky illegal_op output; otherwise they execute as NOP.
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opCode,
  input  logic               in_valid,
  input  logic               resume,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               RegDest,
  output logic               IOToReg,
  output logic               ALUSrc,
  output logic               SLT,
  output logic               MemtoReg,
  output logic               Branch,
  output logic               Jump,
  output logic               JumpR,
  output logic               Jal,
  output logic               Hlt,
  output logic [1:0]         OpIO,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               in_req,
  output logic [2:0]         state_dbg
`ifdef UC_ILLEGAL_TRAP_EN
  ,
  output logic               illegal_op
`endif
);

`ifdef UC_ILLEGAL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  localparam int             CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t               state_r, nxt_state_s;
  logic [OP_W-1:0]      op_q_r, dec_op_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  dec_t                 dec_s;
  ctrl_t                ctrl_r, ctrl_nxt_s;
  logic [ALUOP_W-1:0]   alu_r, alu_nxt_s;
  logic                 static_en_s;
`ifdef UC_ILLEGAL_TRAP_EN
  logic                 illegal_r;
`endif

  // While in DECODE the opcode being latched is decoded directly so the
  // registered outputs of the following state are correct on entry.
  assign dec_op_s = (state_r == DECODE) ? opCode : op_q_r;

  uc_decode #(.OP_W(OP_W)) u_decode (
    .op  (dec_op_s),
    .dec (dec_s)
  );

  // Next-state and MEM wait-counter logic
  always_comb begin
    nxt_state_s = state_r;
    cnt_nxt_s   = {CNT_W{1'b0}};
    case (state_r)
      IDLE:   nxt_state_s = FETCH;
      FETCH:  nxt_state_s = DECODE;
      DECODE: begin
        if (dec_s.is_hlt) begin
          nxt_state_s = HALT;
        end else if (dec_s.illegal) begin
          nxt_state_s = TRAP_ON ? HALT : EXEC;
        end else if (dec_s.is_in) begin
          nxt_state_s = IO_WAIT;
        end else begin
          nxt_state_s = EXEC;
        end
      end
      EXEC:   nxt_state_s = dec_s.is_mem ? MEM : WB;
      MEM: begin
        if (cnt_r == CNT_LAST) begin
          nxt_state_s = WB;
        end else begin
          nxt_state_s = MEM;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      IO_WAIT: nxt_state_s = in_valid ? MEM : IO_WAIT;
      WB:      nxt_state_s = FETCH;
      HALT:    nxt_state_s = resume ? WB : HALT;
      default: nxt_state_s = IDLE;
    endcase
  end

  // Output values for the state about to be entered
  always_comb begin
    ctrl_nxt_s  = {$bits(ctrl_t){1'b0}};
    alu_nxt_s   = {ALUOP_W{1'b0}};
    static_en_s = (nxt_state_s == EXEC) || (nxt_state_s == MEM) ||
                  (nxt_state_s == IO_WAIT) || (nxt_state_s == WB);
    if (static_en_s) begin
      ctrl_nxt_s.reg_dest   = dec_s.reg_dest;
      ctrl_nxt_s.io_to_reg  = dec_s.io_to_reg;
      ctrl_nxt_s.alu_src    = dec_s.alu_src;
      ctrl_nxt_s.slt        = dec_s.slt;
      ctrl_nxt_s.mem_to_reg = dec_s.mem_to_reg;
      ctrl_nxt_s.jal        = dec_s.jal;
      alu_nxt_s             = ALUOP_W'(dec_s.alu_op);
      // OUT is a one-cycle display strobe in EXEC only
      if (dec_s.is_out) begin
        ctrl_nxt_s.op_io = (nxt_state_s == EXEC) ? 2'b10 : 2'b00;
      end else begin
        ctrl_nxt_s.op_io = dec_s.op_io;
      end
    end else begin
      alu_nxt_s = {ALUOP_W{1'b0}};
    end
    case (nxt_state_s)
      FETCH:   ctrl_nxt_s.ir_write = 1'b1;
      MEM: begin
        ctrl_nxt_s.mem_read  = dec_s.mem_read;
        ctrl_nxt_s.mem_write = dec_s.mem_write;
      end
      IO_WAIT: ctrl_nxt_s.in_req = 1'b1;
      WB: begin
        ctrl_nxt_s.pc_write  = 1'b1;
        ctrl_nxt_s.reg_write = dec_s.reg_write;
        ctrl_nxt_s.branch    = dec_s.branch;
        ctrl_nxt_s.jump      = dec_s.jump;
        ctrl_nxt_s.jump_r    = dec_s.jump_r;
      end
      HALT:    ctrl_nxt_s.hlt = 1'b1;
      default: ctrl_nxt_s.hlt = 1'b0;
    endcase
  end

  // State, opcode latch, wait counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      op_q_r  <= {OP_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ctrl_r  <= {$bits(ctrl_t){1'b0}};
      alu_r   <= {ALUOP_W{1'b0}};
`ifdef UC_ILLEGAL_TRAP_EN
      illegal_r <= 1'b0;
`endif
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= cnt_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
      alu_r   <= alu_nxt_s;
      if (state_r == DECODE) begin
        op_q_r <= opCode;
      end
`ifdef UC_ILLEGAL_TRAP_EN
      if ((state_r == DECODE) && dec_s.illegal) begin
        illegal_r <= 1'b1;
      end
`endif
    end
  end

  assign IRWrite   = ctrl_r.ir_write;
  assign PCWrite   = ctrl_r.pc_write;
  assign RegWrite  = ctrl_r.reg_write;
  assign MemWrite  = ctrl_r.mem_write;
  assign MemRead   = ctrl_r.mem_read;
  assign RegDest   = ctrl_r.reg_dest;
  assign IOToReg   = ctrl_r.io_to_reg;
  assign ALUSrc    = ctrl_r.alu_src;
  assign SLT       = ctrl_r.slt;
  assign MemtoReg  = ctrl_r.mem_to_reg;
  assign Branch    = ctrl_r.branch;
  assign Jump      = ctrl_r.jump;
  assign JumpR     = ctrl_r.jump_r;
  assign Jal       = ctrl_r.jal;
  assign Hlt       = ctrl_r.hlt;
  assign in_req    = ctrl_r.in_req;
  assign OpIO      = ctrl_r.op_io;
  assign ALUOp     = alu_r;
  assign state_dbg = state_r;
`ifdef UC_ILLEGAL_TRAP_EN
  assign illegal_op = illegal_r;
`endif

endmodule
